ps2_command_out: RTL and testbench



---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_command_out_if.sv | 18 +
 rtl/ps2_timeout_counter.sv | 26 ++
 rtl/ps2_command_out.sv | 175 +++++++++++++++++
 tb/tb_ps2_command_out.sv | 319 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, command/response bytes, parity helper.
package ps2_pkg;

  typedef enum logic [3:0] {
    PS2_IDLE,
    PS2_INITIATE,
    PS2_WAIT_FOR_CLOCK,
    PS2_TRANSMIT_DATA,
    PS2_TRANSMIT_PARITY,
    PS2_TRANSMIT_STOP,
    PS2_RECEIVE_ACK,
    PS2_COMPLETED,
    PS2_ERROR
  } ps2_cmd_state_e;

  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESEND = 8'hFE;
  localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RSP_BREAK  = 8'hF0;

  // PS/2 frames carry odd parity over the 8 data bits.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_command_out_if.sv
// Command-side handshake between a host controller and the PS/2 transmitter.
interface ps2_command_out_if;
  logic [7:0] the_command;
  logic       send_command;
  logic       busy;
  logic       command_was_sent;
  logic       error_communication_timed_out;

  modport master (
    output the_command, send_command,
    input  busy, command_was_sent, error_communication_timed_out
  );

  modport slave (
    input  the_command, send_command,
    output busy, command_was_sent, error_communication_timed_out
  );
endinterface

// File: rtl/ps2_timeout_counter.sv
// Clearable up-counter with a terminal-count compare against a run-time limit.
module ps2_timeout_counter #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             at_limit
);

  logic [WIDTH-1:0] count_reg;

  assign at_limit = (count_reg == limit);

  // Saturates at the limit so a stalled state never wraps into a false early expiry.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (enable && !at_limit) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_command_out.sv
// Host-to-device PS/2 command transmitter (request-to-send, 8N-odd frame, ack check).
// Optional build macro PS2_CMD_RETRY_EN: one automatic retry after a NACK or 2 ms timeout.
module ps2_command_out
  import ps2_pkg::*;
#(
  parameter int CLOCK_CYCLES_FOR_101US = 5050,
  parameter int CLOCK_CYCLES_FOR_15MS  = 750000,
  parameter int CLOCK_CYCLES_FOR_2MS   = 100000,
  parameter int TIMER_WIDTH            = 20
) (
  input  logic               clk,
  input  logic               reset,
  ps2_command_out_if.slave   cmd,
  input  logic               ps2_clk_posedge,
  input  logic               ps2_clk_negedge,
  input  logic               ps2_data,
  output logic               ps2_clk_drive_low,
  output logic               ps2_data_drive_low
);

  // Terminal counts are one less than the limits so each state lasts exactly the limit.
  localparam logic [TIMER_WIDTH-1:0] LIMIT_101US = TIMER_WIDTH'(CLOCK_CYCLES_FOR_101US - 1);
  localparam logic [TIMER_WIDTH-1:0] LIMIT_15MS  = TIMER_WIDTH'(CLOCK_CYCLES_FOR_15MS - 1);
  localparam logic [TIMER_WIDTH-1:0] LIMIT_2MS   = TIMER_WIDTH'(CLOCK_CYCLES_FOR_2MS - 1);

  ps2_cmd_state_e state_reg, state_next;
  logic [7:0]     shift_reg;
  logic           parity_reg;
  logic [2:0]     bit_index_reg;

  logic                   latch_command;
  logic                   timer_clear;
  logic                   timer_enable;
  logic                   timer_done;
  logic                   failure;
  logic [TIMER_WIDTH-1:0] timer_limit;

  ps2_timeout_counter #(.WIDTH(TIMER_WIDTH)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (timer_clear),
    .enable   (timer_enable),
    .limit    (timer_limit),
    .at_limit (timer_done)
  );

  always_comb begin
    timer_enable = (state_reg != PS2_IDLE) && (state_reg != PS2_COMPLETED) &&
                   (state_reg != PS2_ERROR);
    case (state_reg)
      PS2_INITIATE:       timer_limit = LIMIT_101US;
      PS2_WAIT_FOR_CLOCK: timer_limit = LIMIT_15MS;
      default:            timer_limit = LIMIT_2MS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= PS2_IDLE;
      shift_reg     <= '0;
      parity_reg    <= 1'b0;
      bit_index_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (latch_command) begin
        shift_reg  <= cmd.the_command;
        parity_reg <= odd_parity(cmd.the_command);
      end
      if (state_reg == PS2_WAIT_FOR_CLOCK) begin
        bit_index_reg <= '0;
      end else if (state_reg == PS2_TRANSMIT_DATA && ps2_clk_negedge) begin
        bit_index_reg <= bit_index_reg + 3'd1;
      end
    end
  end

`ifdef PS2_CMD_RETRY_EN
  logic retry_reg;
  logic retry_set;

  always_ff @(posedge clk) begin
    if (reset || state_reg == PS2_IDLE) begin
      retry_reg <= 1'b0;
    end else if (retry_set) begin
      retry_reg <= 1'b1;
    end
  end
`endif

  always_comb begin
    state_next    = state_reg;
    latch_command = 1'b0;
    timer_clear   = 1'b0;
    failure       = 1'b0;
`ifdef PS2_CMD_RETRY_EN
    retry_set     = 1'b0;
`endif
    case (state_reg)
      PS2_IDLE: begin
        timer_clear = 1'b1;
        if (cmd.send_command && !cmd.command_was_sent && !cmd.error_communication_timed_out) begin
          latch_command = 1'b1;
          state_next    = PS2_INITIATE;
        end
      end
      PS2_INITIATE: begin
        if (timer_done) begin
          timer_clear = 1'b1;
          state_next  = PS2_WAIT_FOR_CLOCK;
        end
      end
      PS2_WAIT_FOR_CLOCK: begin
        if (ps2_clk_negedge) begin
          timer_clear = 1'b1;
          state_next  = PS2_TRANSMIT_DATA;
        end else if (timer_done) begin
          state_next = PS2_ERROR;
        end
      end
      PS2_TRANSMIT_DATA: begin
        if (timer_done) failure = 1'b1;
        else if (ps2_clk_negedge && bit_index_reg == 3'd7) state_next = PS2_TRANSMIT_PARITY;
      end
      PS2_TRANSMIT_PARITY: begin
        if (timer_done) failure = 1'b1;
        else if (ps2_clk_negedge) state_next = PS2_TRANSMIT_STOP;
      end
      PS2_TRANSMIT_STOP: begin
        if (timer_done) failure = 1'b1;
        else if (ps2_clk_negedge) state_next = PS2_RECEIVE_ACK;
      end
      PS2_RECEIVE_ACK: begin
        // A coincident negedge masks the posedge, so the ack is only taken on a clean rise.
        if (timer_done) failure = 1'b1;
        else if (!ps2_clk_negedge && ps2_clk_posedge) begin
          if (!ps2_data) state_next = PS2_COMPLETED;
          else           failure    = 1'b1;
        end
      end
      PS2_COMPLETED, PS2_ERROR: begin
        if (!cmd.send_command) state_next = PS2_IDLE;
      end
      default: state_next = PS2_IDLE;
    endcase

    if (failure) begin
`ifdef PS2_CMD_RETRY_EN
      if (!retry_reg) begin
        retry_set   = 1'b1;
        timer_clear = 1'b1;
        state_next  = PS2_INITIATE;
      end else begin
        state_next = PS2_ERROR;
      end
`else
      state_next = PS2_ERROR;
`endif
    end
  end

  always_comb begin
    ps2_clk_drive_low                 = (state_reg == PS2_INITIATE);
    ps2_data_drive_low                = 1'b0;
    cmd.busy                          = (state_reg != PS2_IDLE);
    cmd.command_was_sent              = (state_reg == PS2_COMPLETED);
    cmd.error_communication_timed_out = (state_reg == PS2_ERROR);
    case (state_reg)
      PS2_WAIT_FOR_CLOCK:  ps2_data_drive_low = 1'b1;
      PS2_TRANSMIT_DATA:   ps2_data_drive_low = ~shift_reg[bit_index_reg];
      PS2_TRANSMIT_PARITY: ps2_data_drive_low = ~parity_reg;
      default:             ps2_data_drive_low = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ps2_command_out.sv
// Self-checking bench for ps2_command_out: randomized commands against a frame-level device model.
module tb_ps2_command_out;

  localparam int P101 = 40;
  localparam int P15  = 300;
  localparam int P2   = 200;
  localparam int TW   = 20;

  logic clk = 1'b0;
  logic reset;
  logic ps2_clk_posedge, ps2_clk_negedge, ps2_data;
  logic ps2_clk_drive_low, ps2_data_drive_low;
  int   checks = 0;
  int   errors = 0;

  ps2_command_out_if cmd_if ();

  ps2_command_out #(
    .CLOCK_CYCLES_FOR_101US (P101),
    .CLOCK_CYCLES_FOR_15MS  (P15),
    .CLOCK_CYCLES_FOR_2MS   (P2),
    .TIMER_WIDTH            (TW)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .cmd                (cmd_if),
    .ps2_clk_posedge    (ps2_clk_posedge),
    .ps2_clk_negedge    (ps2_clk_negedge),
    .ps2_data           (ps2_data),
    .ps2_clk_drive_low  (ps2_clk_drive_low),
    .ps2_data_drive_low (ps2_data_drive_low)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected line values seen after negedges 1..11: data LSB first, odd parity, stop, idle.
  function automatic logic [10:0] model_frame(input logic [7:0] c);
    logic [10:0] f;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i] = c[i];
      ones += int'(c[i]);
    end
    f[8]  = (ones % 2 == 0);
    f[9]  = 1'b1;
    f[10] = 1'b1;
    return f;
  endfunction

  task automatic wait_initiate(output int cnt);
    cnt = 0;
    while (ps2_clk_drive_low && cnt < 10000) begin
      cnt++;
      tick();
    end
  endtask

  task automatic run_device(input int n, output logic [10:0] frame);
    frame = '1;
    for (int i = 0; i < n; i++) begin
      ps2_clk_negedge = 1'b1;
      tick();
      ps2_clk_negedge = 1'b0;
      tick();
      frame[i] = ~ps2_data_drive_low;
      if (i < 10) begin
        ps2_data        = 1'b1;
        ps2_clk_posedge = 1'b1;
        tick();
        ps2_clk_posedge = 1'b0;
      end
      tick();
    end
  endtask

  task automatic ack_pulse(input logic val);
    ps2_data        = val;
    ps2_clk_posedge = 1'b1;
    tick();
    ps2_clk_posedge = 1'b0;
    ps2_data        = 1'b1;
  endtask

  // Runs request-to-send and the full frame, then acks; leaves send_command high.
  task automatic send_frame(input logic [7:0] c, input logic ack);
    int cnt;
    logic [10:0] frame;
    cmd_if.the_command  = c;
    cmd_if.send_command = 1'b1;
    tick();
    checks++;
    if (ps2_clk_drive_low !== 1'b1) begin
      errors++;
      $display("FAIL rts_latency cmd=%02h clk_drive_low=%b want 1", c, ps2_clk_drive_low);
    end
    cmd_if.the_command = 8'($urandom);
    wait_initiate(cnt);
    checks++;
    if (cnt != P101) begin
      errors++;
      $display("FAIL rts_length cmd=%02h got %0d cycles want %0d", c, cnt, P101);
    end
    checks++;
    if (ps2_data_drive_low !== 1'b1) begin
      errors++;
      $display("FAIL start_bit cmd=%02h data_drive_low=%b want 1", c, ps2_data_drive_low);
    end
    repeat ($urandom_range(0, 20)) tick();
    run_device(11, frame);
    checks++;
    if (frame !== model_frame(c)) begin
      errors++;
      $display("FAIL frame cmd=%02h got %011b want %011b", c, frame, model_frame(c));
    end
    ack_pulse(ack ? 1'b0 : 1'b1);
  endtask

  task automatic drop_send();
    cmd_if.send_command = 1'b0;
    tick();
    checks++;
    if (cmd_if.busy !== 1'b0 || cmd_if.command_was_sent !== 1'b0 ||
        cmd_if.error_communication_timed_out !== 1'b0) begin
      errors++;
      $display("FAIL return_idle busy=%b sent=%b err=%b want 000", cmd_if.busy,
               cmd_if.command_was_sent, cmd_if.error_communication_timed_out);
    end
  endtask

  task automatic check_sent(input logic [7:0] c);
    checks++;
    if (cmd_if.command_was_sent !== 1'b1 || cmd_if.error_communication_timed_out !== 1'b0) begin
      errors++;
      $display("FAIL ack_done cmd=%02h sent=%b err=%b want 1 0", c, cmd_if.command_was_sent,
               cmd_if.error_communication_timed_out);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ps2_clk_posedge = 1'b0;
    ps2_clk_negedge = 1'b0;
    ps2_data = 1'b1;
    cmd_if.the_command = 8'h00;
    cmd_if.send_command = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({cmd_if.busy, cmd_if.command_was_sent, cmd_if.error_communication_timed_out,
         ps2_clk_drive_low, ps2_data_drive_low} !== 5'b0) begin
      errors++;
      $display("FAIL reset_state outputs=%05b want 00000",
               {cmd_if.busy, cmd_if.command_was_sent, cmd_if.error_communication_timed_out,
                ps2_clk_drive_low, ps2_data_drive_low});
    end
  endtask

  task automatic test_send(input logic [7:0] c);
    send_frame(c, 1'b1);
    check_sent(c);
    $display("send cmd=%02h sent=%b", c, cmd_if.command_was_sent);
    drop_send();
  endtask

  task automatic test_no_clock();
    int cnt;
    logic [7:0] c;
    c = 8'($urandom);
    cmd_if.the_command  = c;
    cmd_if.send_command = 1'b1;
    tick();
    wait_initiate(cnt);
    cnt = 0;
    while (!cmd_if.error_communication_timed_out && cnt < 5000) begin
      tick();
      cnt++;
    end
    checks++;
    if (cnt != P15) begin
      errors++;
      $display("FAIL wait_timeout got %0d cycles want %0d", cnt, P15);
    end
    checks++;
    if (ps2_clk_drive_low !== 1'b0 || ps2_data_drive_low !== 1'b0) begin
      errors++;
      $display("FAIL error_release clk=%b data=%b want 0 0", ps2_clk_drive_low, ps2_data_drive_low);
    end
    $display("no_clock cmd=%02h timeout after %0d cycles", c, cnt);
    drop_send();
  endtask

  task automatic test_nack();
    logic [7:0] c;
    c = 8'($urandom);
    send_frame(c, 1'b0);
`ifdef PS2_CMD_RETRY_EN
    checks++;
    if (ps2_clk_drive_low !== 1'b1 || cmd_if.error_communication_timed_out !== 1'b0) begin
      errors++;
      $display("FAIL retry_start clk=%b err=%b want 1 0", ps2_clk_drive_low,
               cmd_if.error_communication_timed_out);
    end
    begin
      int cnt;
      logic [10:0] frame;
      wait_initiate(cnt);
      run_device(11, frame);
      checks++;
      if (frame !== model_frame(c)) begin
        errors++;
        $display("FAIL retry_frame cmd=%02h got %011b want %011b", c, frame, model_frame(c));
      end
      ack_pulse(1'b0);
      check_sent(c);
    end
`else
    checks++;
    if (cmd_if.error_communication_timed_out !== 1'b1 || cmd_if.command_was_sent !== 1'b0 ||
        ps2_clk_drive_low !== 1'b0 || ps2_data_drive_low !== 1'b0) begin
      errors++;
      $display("FAIL nack_error err=%b sent=%b clk=%b data=%b want 1 0 0 0",
               cmd_if.error_communication_timed_out, cmd_if.command_was_sent,
               ps2_clk_drive_low, ps2_data_drive_low);
    end
`endif
    $display("nack cmd=%02h err=%b sent=%b", c, cmd_if.error_communication_timed_out,
             cmd_if.command_was_sent);
    drop_send();
  endtask

  task automatic test_frame_timeout();
    int cnt;
    logic [10:0] frame;
    cmd_if.the_command  = 8'($urandom);
    cmd_if.send_command = 1'b1;
    tick();
    wait_initiate(cnt);
    run_device(3, frame);
    cnt = 0;
    while (!cmd_if.error_communication_timed_out && cnt < 3000) begin
      tick();
      cnt++;
    end
    checks++;
    if (cmd_if.error_communication_timed_out !== 1'b1 || ps2_clk_drive_low !== 1'b0 ||
        ps2_data_drive_low !== 1'b0) begin
      errors++;
      $display("FAIL frame_timeout err=%b clk=%b data=%b want 1 0 0",
               cmd_if.error_communication_timed_out, ps2_clk_drive_low, ps2_data_drive_low);
    end
    $display("frame_timeout err after %0d cycles", cnt);
    drop_send();
  endtask

  task automatic test_reset_mid();
    int cnt;
    logic [10:0] frame;
    cmd_if.the_command  = 8'($urandom);
    cmd_if.send_command = 1'b1;
    tick();
    wait_initiate(cnt);
    run_device(5, frame);
    reset = 1'b1;
    cmd_if.send_command = 1'b0;
    tick();
    reset = 1'b0;
    checks++;
    if (cmd_if.busy !== 1'b0 || ps2_clk_drive_low !== 1'b0 || ps2_data_drive_low !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid busy=%b clk=%b data=%b want 0 0 0", cmd_if.busy,
               ps2_clk_drive_low, ps2_data_drive_low);
    end
    $display("reset_mid busy=%b", cmd_if.busy);
    tick();
    test_send(8'h55);
  endtask

  task automatic test_back_to_back();
    int starts;
    send_frame(8'h12, 1'b1);
    check_sent(8'h12);
    cmd_if.the_command = 8'hED;
    starts = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ps2_clk_drive_low || !cmd_if.command_was_sent) starts++;
    end
    checks++;
    if (starts != 0) begin
      errors++;
      $display("FAIL hold_done got %0d bad cycles want 0", starts);
    end
    $display("back_to_back held sent=%b", cmd_if.command_was_sent);
    drop_send();
    test_send(8'hED);
  endtask

  initial begin
    test_reset();
    test_send(ps2_pkg::PS2_CMD_ENABLE);
    test_send(ps2_pkg::PS2_CMD_RESET);
    for (int i = 0; i < 3; i++) test_send(8'($urandom));
    test_no_clock();
    test_nack();
    test_frame_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
